instr_issue_unit: RTL and testbench
===================================

Name: instr_issue_unit

Overview:
- Front-end issuer that buffers incoming 3-bit opcodes in a small FIFO and drives the opcode/valid pair consumed by the control unit.
- Handles back-pressure from a downstream stall.
- Flushes buffered instructions when the control unit signals a branch or jump redirect.
- Sits between instruction fetch and the control unit; it is the producer side of the control unit's opcode/valid interface.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- FLUSH_BUBBLES, 2, cycles spent in FLUSH after a redirect; minimum 1.
- CNT_W, 16, issued-instruction counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_opcode  in  3  opcode from fetch.
- in_valid  in  1  in_opcode is valid this cycle.
- in_ready  out  1  unit accepts in_opcode this cycle.
- stall  in  1  downstream cannot take a new instruction; hold outputs.
- branch  in  1  redirect request from the control unit.
- jump  in  1  redirect request from the control unit.
- opcode  out  3  registered opcode to the control unit.
- valid  out  1  registered valid to the control unit.
- occupancy  out  $clog2(DEPTH+1)  current FIFO entry count.
- issued_count  out  CNT_W  issued instructions; present only with ISSUE_COUNT_EN.

Behaviour:
- Reset (async, rst=1):
  - valid=0, opcode=000 (NOP), occupancy=0, issued_count=0.
  - FIFO pointers cleared; state=IDLE.
  - in_ready=1 once rst deasserts.
- in_ready is combinational: in_ready = (occupancy != DEPTH) && (state != FLUSH). No full-bypass.
- Push: occurs on the clock edge when in_valid && in_ready. Unaccepted data is not captured.
- Pop/issue: occurs on the clock edge when state==ISSUE && !stall && occupancy>0. The edge loads opcode<=head, valid<=1 and pops the head.
- Empty or stall:
  - !stall && occupancy==0 (IDLE): valid<=0, opcode<=NOP.
  - stall=1: opcode and valid hold their current values; no pop.
- Simultaneous push and pop with 0<occupancy<DEPTH: occupancy unchanged; ordering strictly FIFO.
- Latency: an opcode accepted at edge t into an empty FIFO appears on opcode/valid after edge t+1. Sustained throughput is 1 per cycle.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked separately, DEPTH+1 states.
- FSM (states IDLE, ISSUE, FLUSH):
  - IDLE -> ISSUE when occupancy>0, or when a push occurs this edge.
  - ISSUE -> IDLE when the last entry pops with no simultaneous push.
  - Any state -> FLUSH on an edge where (branch || jump) is sampled high.
  - FLUSH -> IDLE after FLUSH_BUBBLES cycles, tracked by a down-counter.
- Redirect (branch||jump=1 at an edge):
  - FIFO emptied; occupancy<=0.
  - valid<=0, opcode<=NOP.
  - Any push on the same edge is dropped, since in_ready is not yet low.
  - Redirect has priority over stall and over pop.
  - A redirect during FLUSH restarts the bubble counter.
- Reset mid-operation: all state discarded immediately; no partial issue.

Optional Feature:
- Macro: ISSUE_COUNT_EN.
- Defined:
  - issued_count port present; increments by 1 on every pop edge.
  - Wraps at 2^CNT_W; cleared only by rst.
  - Flushed entries are not counted.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Shared package ctrl_pkg:
  - 3-bit opcode typedef.
  - Constants OPCODE_NOP=000, ADD=001, SUB=010, AND=011, OR=100.
  - Issue FSM state enum {IDLE, ISSUE, FLUSH}.
  - The control unit adopts the same package.
- One natural sub-module: issue_fifo, a parameterised sync FIFO.
  - Inputs: push, pop, clear.
  - Outputs: head, occupancy, full, empty.
  - FSM and output register stay in instr_issue_unit.

Test Plan:
- Reset check: rst pulse mid-run with 3 entries queued -> immediately valid=0, opcode=000, occupancy=0; in_ready=1 after release.
- Single issue: push ADD(001) at edge t into an empty FIFO -> opcode=001, valid=1 after edge t+1; valid=0 the following cycle.
- Full/back-pressure, DEPTH=4, stall=1:
  - Push ADD, SUB, AND, OR -> occupancy=4, in_ready=0; a 5th in_valid is not accepted.
  - Release stall -> 001, 010, 011, 100 issued on consecutive cycles.
- Stall hold: issuing SUB(010), raise stall for 3 cycles -> opcode=010, valid=1 held; occupancy unchanged; resumes in order.
- Redirect:
  - occupancy=3, assert jump for 1 cycle with in_valid=1 -> occupancy=0, valid=0, opcode=000.
  - in_ready=0 for 2 cycles, then 1; the pushed opcode is dropped.
- Counter (ISSUE_COUNT_EN defined): issue 5 instructions, flush 2 -> issued_count=5.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module : ctrl_pkg
// Brief  : Opcode type, opcode constants and issue FSM states shared with the
//          control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OPCODE_NOP = 3'b000;
    localparam opcode_t OPCODE_ADD = 3'b001;
    localparam opcode_t OPCODE_SUB = 3'b010;
    localparam opcode_t OPCODE_AND = 3'b011;
    localparam opcode_t OPCODE_OR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } issue_state_t;

endpackage : ctrl_pkg

`default_nettype wire

// File: rtl/issue_fifo.sv
// ============================================================================
// Module : issue_fifo
// Brief  : Parameterised synchronous opcode FIFO with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_fifo
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  opcode_t                      push_data,
    input  logic                         pop,
    input  logic                         clear,
    output opcode_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    opcode_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [OW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == OW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;
    assign head      = r_mem[r_rd_ptr];
    assign occupancy = r_count;

    // Pointers are exactly log2(DEPTH) bits, so they wrap without compare logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + OW'(w_do_push) - OW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule : issue_fifo

`default_nettype wire

// File: rtl/instr_issue_unit.sv
// ============================================================================
// Module : instr_issue_unit
// Brief  : Buffers fetched opcodes and issues them to the control unit with
//          stall hold and branch/jump flush. ISSUE_COUNT_EN adds issued_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_issue_unit
    import ctrl_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int FLUSH_BUBBLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  opcode_t                      in_opcode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         jump,
    output opcode_t                      opcode,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef ISSUE_COUNT_EN
    ,
    output logic [CNT_W-1:0]             issued_count
`endif
);

    localparam int OW = $clog2(DEPTH + 1);
    localparam int BW = (FLUSH_BUBBLES > 1) ? $clog2(FLUSH_BUBBLES) : 1;

    issue_state_t    r_state;
    issue_state_t    w_next_state;
    logic [BW-1:0]   r_bubble;
    logic            w_redirect;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    opcode_t         w_head;

    assign w_redirect = branch || jump;
    assign in_ready   = !w_full && (r_state != FLUSH);
    // in_ready does not see the redirect, so a push on a redirect edge is dropped here.
    assign w_push     = in_valid && in_ready && !w_redirect;
    assign w_pop      = (r_state == ISSUE) && !stall && !w_empty && !w_redirect;

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_opcode),
        .pop       (w_pop),
        .clear     (w_redirect),
        .head      (w_head),
        .occupancy (occupancy),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bubble <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_redirect) begin
                r_bubble <= BW'(FLUSH_BUBBLES - 1);
            end else if ((r_state == FLUSH) && (r_bubble != '0)) begin
                r_bubble <= r_bubble - BW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_redirect) begin
            w_next_state = FLUSH;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty || w_push) begin
                        w_next_state = ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_pop && !w_push && (occupancy == OW'(1))) begin
                        w_next_state = IDLE;
                    end
                end
                FLUSH: begin
                    if (r_bubble == '0) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Redirect wins over stall, stall wins over pop/idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode <= OPCODE_NOP;
            valid  <= 1'b0;
        end else if (w_redirect) begin
            opcode <= OPCODE_NOP;
            valid  <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                opcode <= w_head;
                valid  <= 1'b1;
            end else begin
                opcode <= OPCODE_NOP;
                valid  <= 1'b0;
            end
        end
    end

`ifdef ISSUE_COUNT_EN
    logic [CNT_W-1:0] r_issued;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
        end else if (w_pop) begin
            r_issued <= r_issued + CNT_W'(1);
        end
    end

    assign issued_count = r_issued;
`endif

endmodule : instr_issue_unit

`default_nettype wire

// File: tb/tb_instr_issue_unit.sv
// ============================================================================
// Module : tb_instr_issue_unit
// Brief  : Directed and randomized self-checking bench for instr_issue_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_unit;
    import ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int FB    = 2;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_opcode = 3'b000;
    logic       in_valid = 1'b0;
    logic       stall = 1'b0;
    logic       branch = 1'b0;
    logic       jump = 1'b0;
    logic       in_ready;
    logic [2:0] opcode;
    logic       valid;
    logic [2:0] occupancy;
`ifdef ISSUE_COUNT_EN
    logic [CNT_W-1:0] issued_count;
`endif

    always #5 clk = ~clk;

    instr_issue_unit #(
        .DEPTH         (DEPTH),
        .FLUSH_BUBBLES (FB),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_opcode    (in_opcode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .branch       (branch),
        .jump         (jump),
        .opcode       (opcode),
        .valid        (valid),
        .occupancy    (occupancy)
`ifdef ISSUE_COUNT_EN
        ,
        .issued_count (issued_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending opcodes plus a bubble countdown.
    // Issue happens whenever entries are queued, no flush is pending and no stall.
    logic [2:0] mq[$];
    int         m_flush = 0;
    logic [2:0] m_op    = 3'b000;
    logic       m_valid = 1'b0;
    int         m_cnt   = 0;
    bit         m_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_flush = 0;
            m_op    = 3'b000;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            m_ready = (mq.size() != DEPTH) && (m_flush == 0);
            if (branch || jump) begin
                mq.delete();
                m_op    = 3'b000;
                m_valid = 1'b0;
                m_flush = FB;
            end else begin
                if (m_flush == 0 && mq.size() > 0 && !stall) begin
                    m_op    = mq.pop_front();
                    m_valid = 1'b1;
                    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
                end else if (!stall) begin
                    m_op    = 3'b000;
                    m_valid = 1'b0;
                end
                if (in_valid && m_ready) mq.push_back(in_opcode);
                if (m_flush > 0) m_flush--;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("opcode", opcode, m_op);
            chk("valid", valid, m_valid);
            chk("occupancy", occupancy, mq.size());
            chk("in_ready", in_ready, int'((mq.size() != DEPTH) && (m_flush == 0)));
`ifdef ISSUE_COUNT_EN
            chk("issued_count", issued_count, m_cnt);
`endif
        end
    end

    task automatic cyc(input logic v, input logic [2:0] op, input logic st,
                       input logic br, input logic jp);
        in_valid  = v;
        in_opcode = op;
        stall     = st;
        branch    = br;
        jump      = jp;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] exp_seq [4];
        int         base_cnt;
        exp_seq  = '{3'b001, 3'b010, 3'b011, 3'b100};
        base_cnt = 0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_opcode", opcode, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Single issue: one-cycle latency, then back to NOP.
        cyc(1'b1, OPCODE_ADD, 1'b0, 1'b0, 1'b0);
        chk("single_occ_after_push", occupancy, 1);
        chk("single_valid_after_push", valid, 0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("single_opcode", opcode, 1);
        chk("single_valid", valid, 1);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("single_valid_drop", valid, 0);
        chk("single_opcode_nop", opcode, 0);

        // Fill under stall, reject a fifth entry, then drain in order.
        cyc(1'b1, OPCODE_ADD, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_SUB, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_AND, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_OR,  1'b1, 1'b0, 1'b0);
        chk("full_occ", occupancy, 4);
        chk("full_in_ready", in_ready, 0);
        cyc(1'b1, 3'b101, 1'b1, 1'b0, 1'b0);
        chk("full_reject_occ", occupancy, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
            chk("drain_opcode", opcode, exp_seq[i]);
            chk("drain_valid", valid, 1);
        end
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("drain_done_valid", valid, 0);

        // Stall holds an issued SUB for three cycles.
        cyc(1'b1, OPCODE_SUB, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_AND, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("hold_first_opcode", opcode, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, OPCODE_NOP, 1'b1, 1'b0, 1'b0);
            chk("hold_opcode", opcode, 2);
            chk("hold_valid", valid, 1);
            chk("hold_occ", occupancy, 1);
        end
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("hold_resume_opcode", opcode, 3);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);

        // Redirect with a simultaneous push: everything dropped, two bubbles.
        cyc(1'b1, OPCODE_ADD, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_SUB, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_AND, 1'b1, 1'b0, 1'b0);
        chk("redir_pre_occ", occupancy, 3);
        cyc(1'b1, OPCODE_OR, 1'b1, 1'b0, 1'b1);
        chk("redir_occ", occupancy, 0);
        chk("redir_valid", valid, 0);
        chk("redir_opcode", opcode, 0);
        chk("redir_bubble1_ready", in_ready, 0);
        cyc(1'b1, OPCODE_SUB, 1'b0, 1'b0, 1'b0);
        chk("redir_bubble2_ready", in_ready, 0);
        chk("redir_bubble2_occ", occupancy, 0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("redir_after_ready", in_ready, 1);
        chk("redir_after_occ", occupancy, 0);
        chk("redir_after_valid", valid, 0);

        // Five issued, two flushed.
`ifdef ISSUE_COUNT_EN
        base_cnt = int'(issued_count);
`endif
        for (int i = 0; i < 5; i++) cyc(1'b1, OPCODE_ADD, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_SUB, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, OPCODE_AND, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
`ifdef ISSUE_COUNT_EN
        chk("count_delta", int'(issued_count) - base_cnt, 5);
`endif

        // Asynchronous reset with three entries still queued.
        for (int i = 0; i < 4; i++) cyc(1'b1, exp_seq[i], 1'b1, 1'b0, 1'b0);
        cyc(1'b0, OPCODE_NOP, 1'b0, 1'b0, 1'b0);
        chk("prerst_valid", valid, 1);
        chk("prerst_occ", occupancy, 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_opcode", opcode, 0);
        chk("midrst_occ", occupancy, 0);
`ifdef ISSUE_COUNT_EN
        chk("midrst_count", issued_count, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", in_ready, 1);
        @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 9) < 7),
                3'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 39) == 0));
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_issue_unit

`default_nettype wire
